// File: rtl/if_prefetch_queue.sv
// Instruction-fetch stage: issues word fetches (1-cycle memory latency) and buffers instr/PC pairs for decode.
// Optional macro IF_PREFETCH_PERF_EN adds saturating starvation and flush counters.
module if_prefetch_queue #(
  parameter int             DEPTH    = 4,
  parameter int             AW       = 32,
  parameter logic [AW-1:0]  RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst,
  output logic [AW-1:0] imem_addr,
  output logic          imem_req,
  input  logic [31:0]   imem_rdata,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_pc,
  output logic          id_valid,
  input  logic          id_ready,
  output logic [31:0]   id_instr,
  output logic [AW-1:0] id_pc
`ifdef IF_PREFETCH_PERF_EN
  ,
  output logic [31:0]   perf_starve_cnt,
  output logic [31:0]   perf_flush_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] resp_pc_q;
  logic          inflight_q;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [31:0]   instr_mem_q [DEPTH];
  logic [AW-1:0] pc_mem_q    [DEPTH];

  logic          issue, push, pop;
  logic [CW:0]   occupancy;

  // Credit counts the in-flight fetch so a returning response always has a free slot.
  assign occupancy = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
  assign issue     = !rst && !redirect_valid && (occupancy < DEPTH_C);
  assign push      = inflight_q && !redirect_valid;
  assign pop       = id_valid && id_ready && !redirect_valid;

  assign imem_addr = pc_q;
  assign imem_req  = issue;
  assign id_valid  = (count_q != '0);
  assign id_instr  = id_valid ? instr_mem_q[rd_ptr_q] : 32'h0;
  assign id_pc     = id_valid ? pc_mem_q[rd_ptr_q]    : '0;

  always_comb begin
    pc_d    = pc_q;
    count_d = count_q;
    if (redirect_valid) begin
      pc_d    = {redirect_pc[AW-1:2], 2'b00};
      count_d = '0;
    end else begin
      if (issue) pc_d = pc_q + AW'(4);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      resp_pc_q  <= '0;
      inflight_q <= 1'b0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      pc_q       <= pc_d;
      count_q    <= count_d;
      inflight_q <= issue;
      if (issue) resp_pc_q <= pc_q;
      if (redirect_valid) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      end
    end
  end

  // Storage needs no reset: reads are masked by count while empty.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      instr_mem_q[wr_ptr_q] <= imem_rdata;
      pc_mem_q[wr_ptr_q]    <= resp_pc_q;
    end
  end

`ifdef IF_PREFETCH_PERF_EN
  logic [31:0] perf_starve_q, perf_flush_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_starve_q <= '0;
      perf_flush_q  <= '0;
    end else begin
      if (id_ready && !id_valid && (perf_starve_q != '1)) perf_starve_q <= perf_starve_q + 32'd1;
      if (redirect_valid && (perf_flush_q != '1))         perf_flush_q  <= perf_flush_q + 32'd1;
    end
  end

  assign perf_starve_cnt = perf_starve_q;
  assign perf_flush_cnt  = perf_flush_q;
`endif

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Bench for if_prefetch_queue: queue-level reference model compared every cycle, directed pins, random traffic.
module tb_if_prefetch_queue;
  localparam int DEPTH = 4;
  localparam logic [31:0] XOR_K = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr, imem_rdata;
  logic        imem_req;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid, id_ready;
  logic [31:0] id_instr, id_pc;
`ifdef IF_PREFETCH_PERF_EN
  logic [31:0] perf_starve_cnt, perf_flush_cnt;
  logic [31:0] w_starve, w_flush;
`endif

  // Second instance exercises PC wrap-around.
  logic [31:0] w_addr, w_rdata, w_instr, w_pc;
  logic        w_req, w_valid;

  always #5 clk = ~clk;

  if_prefetch_queue #(.DEPTH(DEPTH), .AW(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_req(imem_req), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc)
`ifdef IF_PREFETCH_PERF_EN
    , .perf_starve_cnt(perf_starve_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  if_prefetch_queue #(.DEPTH(DEPTH), .AW(32), .RESET_PC(32'hFFFF_FFF8)) dut_w (
    .clk(clk), .rst(rst), .imem_addr(w_addr), .imem_req(w_req), .imem_rdata(w_rdata),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .id_valid(w_valid), .id_ready(1'b1), .id_instr(w_instr), .id_pc(w_pc)
`ifdef IF_PREFETCH_PERF_EN
    , .perf_starve_cnt(w_starve), .perf_flush_cnt(w_flush)
`endif
  );

  // Memories with exactly one cycle of latency; garbage when not requested.
  always @(posedge clk) begin
    imem_rdata <= imem_req ? (imem_addr ^ XOR_K) : 32'hDEAD_BEEF;
    w_rdata    <= w_req    ? (w_addr ^ XOR_K)    : 32'hDEAD_BEEF;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: queue of buffered PCs, one outstanding fetch, next fetch PC.
  logic [31:0] exp_q[$];
  bit          m_inf;
  logic [31:0] m_inf_pc, m_pc;
  bit          mv = 0;
  bit          exp_req;
  logic [31:0] m_starve, m_flush;

  always @(negedge clk) begin
    if (rst) begin
      check("imem_req_in_reset", 32'(imem_req), 32'h0);
      exp_q.delete();
      m_inf = 0; m_pc = 32'h0; m_starve = 0; m_flush = 0;
      mv = 1;
    end else if (mv) begin
      exp_req = !redirect_valid && ((exp_q.size() + int'(m_inf)) < DEPTH);
      check("imem_req", 32'(imem_req), 32'(exp_req));
      check("imem_addr", imem_addr, m_pc);
      check("id_valid", 32'(id_valid), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        check("id_pc", id_pc, exp_q[0]);
        check("id_instr", id_instr, exp_q[0] ^ XOR_K);
      end else begin
        check("id_pc_empty", id_pc, 32'h0);
        check("id_instr_empty", id_instr, 32'h0);
      end
`ifdef IF_PREFETCH_PERF_EN
      check("perf_starve", perf_starve_cnt, m_starve);
      check("perf_flush", perf_flush_cnt, m_flush);
      if (id_ready && exp_q.size() == 0) m_starve++;
      if (redirect_valid) m_flush++;
`endif
      if (redirect_valid) begin
        exp_q.delete();
        m_inf = 0;
        m_pc  = {redirect_pc[31:2], 2'b00};
      end else begin
        if (id_ready && exp_q.size() != 0) void'(exp_q.pop_front());
        if (m_inf) exp_q.push_back(m_inf_pc);
        m_inf = exp_req;
        if (exp_req) begin
          m_inf_pc = m_pc;
          m_pc     = m_pc + 32'd4;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
    step(); step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; id_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;

    // Latency from reset and wrap-around instance.
    do_reset();
    @(negedge clk);
    check("c1_valid", 32'(id_valid), 32'h0);
    check("c1_req", 32'(imem_req), 32'h1);
    check("c1_addr", imem_addr, 32'h0);
    step(); @(negedge clk);
    check("c2_valid", 32'(id_valid), 32'h0);
    step(); @(negedge clk);
    check("c3_valid", 32'(id_valid), 32'h1);
    check("c3_pc", id_pc, 32'h0);
    check("c3_instr", id_instr, 32'hA5A5_0000);
    check("wrap_pc0", w_pc, 32'hFFFF_FFF8);
    step(); @(negedge clk);
    check("c4_pc", id_pc, 32'h4);
    check("wrap_pc1", w_pc, 32'hFFFF_FFFC);
    step(); @(negedge clk);
    check("c5_pc", id_pc, 32'h8);
    check("c5_instr", id_instr, 32'hA5A5_0008);
    check("wrap_pc2", w_pc, 32'h0000_0000);
    repeat (8) step();

    // Back-pressure fills exactly DEPTH entries, then drains without gaps.
    do_reset();
    id_ready = 1'b0;
    repeat (10) step();
    @(negedge clk);
    check("full_valid", 32'(id_valid), 32'h1);
    check("full_req", 32'(imem_req), 32'h0);
    check("full_addr", imem_addr, 32'h10);
    id_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step(); @(negedge clk);
      check("drain_pc", id_pc, 32'(4 * (k + 1)));
    end
    step();

    // Redirect while full; target low bits dropped.
    id_ready = 1'b0;
    repeat (8) step();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
    step();
    redirect_valid = 1'b0; id_ready = 1'b1;
    @(negedge clk);
    check("rd1_valid", 32'(id_valid), 32'h0);
    check("rd1_addr", imem_addr, 32'h100);
    step(); @(negedge clk);
    check("rd2_valid", 32'(id_valid), 32'h0);
    step(); @(negedge clk);
    check("rd3_valid", 32'(id_valid), 32'h1);
    check("rd3_pc", id_pc, 32'h100);

    // Redirect colliding with pop and returning response.
    repeat (8) step();
    redirect_valid = 1'b1; redirect_pc = 32'h2000;
    step();
    redirect_valid = 1'b0;
    step(); step(); @(negedge clk);
    check("rdpop_pc", id_pc, 32'h2000);

    // Back-to-back redirects: last wins.
    repeat (3) step();
    redirect_valid = 1'b1; redirect_pc = 32'h300;
    step();
    redirect_pc = 32'h400;
    step();
    redirect_valid = 1'b0;
    step(); step(); @(negedge clk);
    check("b2b_pc", id_pc, 32'h400);
    step();

    // Random traffic, including mid-operation resets.
    for (int i = 0; i < 600; i++) begin
      rst            = ($urandom_range(0, 99) < 1);
      redirect_valid = ($urandom_range(0, 99) < 6);
      redirect_pc    = $urandom;
      id_ready       = ($urandom_range(0, 3) != 0);
      step();
    end
    rst = 1'b0; redirect_valid = 1'b0; id_ready = 1'b1;
    repeat (6) step();

`ifdef IF_PREFETCH_PERF_EN
    do_reset();
    id_ready = 1'b1;
    repeat (6) step();
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    step();
    redirect_valid = 1'b0;
    repeat (6) step();
    redirect_valid = 1'b1; redirect_pc = 32'h80;
    step();
    redirect_valid = 1'b0;
    repeat (6) step();
    @(negedge clk);
    check("perf_flush_lit", perf_flush_cnt, 32'd2);
    check("perf_starve_lit", perf_starve_cnt, 32'd6);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
